ppm_frame_decoder: RTL and testbench
====================================

# ppm_frame_decoder

Downstream consumer of the start-of-frame pulse `F_en` in the PPM decoder datapath. Once `F_en` fires, the block times a fixed frame of pulse-position-modulated symbols on `ppm_in`. It decodes each symbol to the index of the slot that carries the pulse and presents one registered data word per symbol with a per-symbol error flag. At the end of the frame it raises a frame-done strobe with an aggregate error flag.

## Interface
- `SLOT_CYC`, default 8: clock cycles per slot. Must be a power of 2 and ≥ 4.
- `PPM_BITS`, default 2: bits per symbol. Slots per symbol M = 2^PPM_BITS.
- `SYMS`, default 8: symbols per frame, ≥ 1.

Ports:
- `clk` in 1: sole clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `F_en` in 1: one-cycle start-of-frame pulse from the edge-detect stage.
- `ppm_in` in 1: PPM pulse line, already synchronised to `clk`.
- `data_out` out PPM_BITS: decoded slot index of the last completed symbol.
- `data_valid` out 1: one-cycle strobe; `data_out` and `sym_err` are valid.
- `sym_err` out 1: last symbol had zero pulses or more than one pulse.
- `frame_done` out 1: one-cycle strobe coincident with the last symbol's `data_valid`.
- `frame_err` out 1: valid with `frame_done`; high if any `sym_err` occurred in the frame.
- `busy` out 1: high while in RUN.

## Operation
- FSM states are IDLE and RUN.
- IDLE:
  - Counters are held at 0.
  - `F_en`=1 moves the FSM to RUN.
- RUN uses three counters:
  - `cyc_cnt` runs 0..SLOT_CYC-1.
  - `slot_cnt` runs 0..M-1.
  - `sym_cnt` runs 0..SYMS-1.
  - `cyc_cnt` increments every cycle and wraps. On its wrap `slot_cnt` advances. On the `slot_cnt` wrap `sym_cnt` advances.
- Sampling:
  - `ppm_in` is sampled once per slot, at `cyc_cnt` = SLOT_CYC/2.
  - A high sample increments `pulse_cnt`, which is 2 bits and saturates at 2.
  - On the first high sample, the current `slot_cnt` is latched into `cap_slot`.
- End of symbol (last cycle of slot M-1):
  - Next cycle, `data_valid`=1.
  - `data_out` = `cap_slot`, or 0 if `pulse_cnt`=0.
  - `sym_err` = (`pulse_cnt` ≠ 1). With multiple pulses, the first pulse wins.
  - `pulse_cnt` is cleared for the next symbol.
- `frame_err` accumulates the OR of all `sym_err` values in the frame. It is cleared on frame start.
- End of the last symbol: the FSM moves to IDLE. `frame_done` and `frame_err` are presented with the final `data_valid`.
- `F_en` during RUN restarts the frame:
  - All counters, `pulse_cnt` and the `frame_err` accumulator are cleared.
  - The partial symbol is discarded and no strobe is issued for it.
  - The next cycle is cycle 0 of symbol 0.
- `F_en` in the same cycle as an end-of-symbol boundary: the completed symbol's strobe is still issued next cycle, then the restart applies.
- Reset values: state=IDLE, all counters 0, `data_out`=0, `data_valid`=0, `sym_err`=0, `frame_done`=0, `frame_err`=0, `busy`=0.
- Reset mid-frame aborts with no strobes.

## Timing
- `F_en` high in cycle T: cycle T+1 is `cyc_cnt`=0, `slot_cnt`=0, `sym_cnt`=0, and `busy`=1 from T+1.
- Sample cycle for symbol k, slot s: T+1 + k·M·SLOT_CYC + s·SLOT_CYC + SLOT_CYC/2.
- `data_valid` for symbol k occurs at T+1 + (k+1)·M·SLOT_CYC. This is one cycle of registered latency after the symbol ends.
- `frame_done` occurs at T+1 + SYMS·M·SLOT_CYC. `busy`=0 in that same cycle.
- A new `F_en` in that cycle is accepted, giving back-to-back frames.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- `ppm_pkg` holds:
  - the state enum (IDLE, RUN);
  - localparams for M, counter widths ($clog2) and the sample offset SLOT_CYC/2.
- Sub-module `ppm_slot_timer` owns `cyc_cnt` and `slot_cnt`. It has `clear`/`run` inputs and outputs `sample_pt`, `slot_idx` and `sym_end`.
- The top level holds the FSM, `sym_cnt`, pulse capture and output registers.

## Test plan
All scenarios use the defaults: 4-PPM, 8-cycle slots, 32-cycle symbols, 256-cycle frames.
- Clean frame:
  - Stimulus: `F_en` at T, then pulses in slots 0,1,2,3,3,2,1,0.
  - Required: `data_valid` at T+33, T+65, …, T+257 with `data_out` 0,1,2,3,3,2,1,0 and `sym_err`=0.
  - Required: `frame_done`=1 and `frame_err`=0 at T+257.
- Missing and double pulse:
  - Stimulus: symbol 2 has no pulse; symbol 5 has pulses in slots 1 and 3.
  - Required: symbol 2 gives `data_out`=0, `sym_err`=1. Symbol 5 gives `data_out`=1, `sym_err`=1.
  - Required: `frame_err`=1 at `frame_done`.
- Sampling window:
  - Stimulus: a pulse high only at offsets 0–3 of slot 2 in symbol 0.
  - Required: detection fails, so `sym_err`=1.
  - Stimulus: the pulse is high at offset 4.
  - Required: decodes as 2.
- Restart:
  - Stimulus: `F_en` at T, second `F_en` at T+50.
  - Required: symbol 0 strobe at T+33; no strobe at T+65; new symbol 0 strobe at T+83.
  - Required: `frame_done` at T+307.
- Back-to-back and reset:
  - Stimulus: `F_en` in the `frame_done` cycle.
  - Required: `busy` returns high the next cycle and the second frame decodes correctly.
  - Stimulus: `rst` asserted at T+100 for one cycle.
  - Required: all outputs 0, state IDLE, and no further strobes until the next `F_en`.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared types and default geometry for the PPM frame decoder.
package ppm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned SLOT_CYC_DEF   = 8;
    localparam int unsigned PPM_BITS_DEF   = 2;
    localparam int unsigned SYMS_DEF       = 8;
    localparam int unsigned M_DEF          = 1 << PPM_BITS_DEF;
    localparam int unsigned CYC_W_DEF      = $clog2(SLOT_CYC_DEF);
    localparam int unsigned SLOT_W_DEF     = PPM_BITS_DEF;
    localparam int unsigned SYM_W_DEF      = $clog2(SYMS_DEF);
    localparam int unsigned SAMPLE_OFS_DEF = SLOT_CYC_DEF / 2;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// Cycle-within-slot and slot-within-symbol counters; flags the sample point and symbol end.
module ppm_slot_timer
    import ppm_pkg::*;
#(
    parameter int unsigned SLOT_CYC = SLOT_CYC_DEF,
    parameter int unsigned PPM_BITS = PPM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                run,
    output logic                sample_pt,
    output logic [PPM_BITS-1:0] slot_idx,
    output logic                sym_end
);

    localparam int unsigned M          = 1 << PPM_BITS;
    localparam int unsigned CYC_W      = cnt_width(SLOT_CYC);
    localparam int unsigned SAMPLE_OFS = SLOT_CYC / 2;

    logic [CYC_W-1:0]    cyc_cnt;
    logic [PPM_BITS-1:0] slot_cnt;
    logic                cyc_wrap;

    assign cyc_wrap = (cyc_cnt == CYC_W'(SLOT_CYC - 1));

    // Free-running slot timing while running; clear forces both counters back to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cyc_cnt  <= '0;
            slot_cnt <= '0;
        end else if (run) begin
            if (cyc_wrap) begin
                cyc_cnt  <= '0;
                slot_cnt <= (slot_cnt == PPM_BITS'(M - 1)) ? '0 : slot_cnt + 1'b1;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    assign sample_pt = run && (cyc_cnt == CYC_W'(SAMPLE_OFS));
    assign slot_idx  = slot_cnt;
    assign sym_end   = run && cyc_wrap && (slot_cnt == PPM_BITS'(M - 1));

endmodule

// File: rtl/ppm_frame_decoder.sv
// Times a fixed frame of PPM symbols after a start pulse and emits one decoded word per symbol.
module ppm_frame_decoder
    import ppm_pkg::*;
#(
    parameter int unsigned SLOT_CYC = SLOT_CYC_DEF,
    parameter int unsigned PPM_BITS = PPM_BITS_DEF,
    parameter int unsigned SYMS     = SYMS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                F_en,
    input  logic                ppm_in,
    output logic [PPM_BITS-1:0] data_out,
    output logic                data_valid,
    output logic                sym_err,
    output logic                frame_done,
    output logic                frame_err,
    output logic                busy
);

    localparam int unsigned SYM_W = cnt_width(SYMS);

    state_t              state;
    logic [SYM_W-1:0]    sym_cnt;
    logic [1:0]          pulse_cnt;
    logic [PPM_BITS-1:0] cap_slot;
    logic                err_acc;

    logic                tmr_clear;
    logic                tmr_run;
    logic                sample_pt;
    logic                sym_end;
    logic [PPM_BITS-1:0] slot_idx;
    logic                cur_err;
    logic                last_sym;

    assign tmr_run   = (state == RUN);
    assign tmr_clear = (state == IDLE) || F_en;
    assign cur_err   = (pulse_cnt != 2'd1);
    assign last_sym  = (sym_cnt == SYM_W'(SYMS - 1));

    ppm_slot_timer #(
        .SLOT_CYC (SLOT_CYC),
        .PPM_BITS (PPM_BITS)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (tmr_clear),
        .run       (tmr_run),
        .sample_pt (sample_pt),
        .slot_idx  (slot_idx),
        .sym_end   (sym_end)
    );

    // Frame FSM, symbol counting, pulse capture and registered result strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sym_cnt    <= '0;
            pulse_cnt  <= '0;
            cap_slot   <= '0;
            err_acc    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sym_err    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (F_en) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        sym_cnt   <= '0;
                        pulse_cnt <= '0;
                        err_acc   <= 1'b0;
                    end
                end
                RUN: begin
                    // A completed symbol is always reported, even when a restart lands on it.
                    if (sym_end) begin
                        data_valid <= 1'b1;
                        data_out   <= (pulse_cnt == 2'd0) ? '0 : cap_slot;
                        sym_err    <= cur_err;
                        if (last_sym) begin
                            frame_done <= 1'b1;
                            frame_err  <= err_acc | cur_err;
                        end
                    end
                    if (F_en) begin
                        sym_cnt   <= '0;
                        pulse_cnt <= '0;
                        err_acc   <= 1'b0;
                    end else if (sym_end) begin
                        pulse_cnt <= '0;
                        err_acc   <= err_acc | cur_err;
                        if (last_sym) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            sym_cnt <= '0;
                        end else begin
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                    end else if (sample_pt && ppm_in) begin
                        // First pulse of the symbol decides the slot; count saturates at two.
                        if (pulse_cnt == 2'd0) begin
                            cap_slot <= slot_idx;
                        end
                        if (pulse_cnt != 2'd2) begin
                            pulse_cnt <= pulse_cnt + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppm_frame_decoder.sv
// Scoreboard bench for ppm_frame_decoder: per-slot waveforms drive the line, a frame-level model predicts strobes.
module tb_ppm_frame_decoder;

    localparam int SC        = 8;
    localparam int PB        = 2;
    localparam int M         = 4;
    localparam int NS        = 8;
    localparam int SYM_LEN   = SC * M;
    localparam int FRAME_LEN = SYM_LEN * NS;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          F_en   = 1'b0;
    logic          ppm_in = 1'b0;
    logic [PB-1:0] data_out;
    logic          data_valid;
    logic          sym_err;
    logic          frame_done;
    logic          frame_err;
    logic          busy;

    ppm_frame_decoder #(
        .SLOT_CYC (SC),
        .PPM_BITS (PB),
        .SYMS     (NS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .F_en       (F_en),
        .ppm_in     (ppm_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sym_err    (sym_err),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [PB-1:0] data;
        logic          err;
        logic          done;
        logic          ferr;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [SC-1:0] wave [NS][M];

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe pops the oldest expectation; an overdue expectation is a missed strobe.
    always @(negedge clk) begin
        if (data_valid || frame_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: data_valid=%0d frame_done=%0d at cycle %0d, expected none",
                         data_valid, frame_done, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.at);
                chk("data_valid", int'(data_valid), 1);
                chk("data_out", int'(data_out), int'(e.data));
                chk("sym_err", int'(sym_err), int'(e.err));
                chk("frame_done", int'(frame_done), int'(e.done));
                if (e.done) chk("frame_err", int'(frame_err), int'(e.ferr));
            end
        end else if (sb.size() > 0 && sb[0].at <= cyc) begin
            total++;
            bad++;
            $display("FAIL missed_strobe: no strobe at cycle %0d, expected one at cycle %0d", cyc, sb[0].at);
            void'(sb.pop_front());
        end
    end

    task automatic clear_wave();
        for (int k = 0; k < NS; k++)
            for (int s = 0; s < M; s++)
                wave[k][s] = '0;
    endtask

    task automatic single_pulses();
        clear_wave();
        for (int k = 0; k < NS; k++) wave[k][$urandom_range(0, M - 1)] = '1;
    endtask

    // Random line activity: noise off the sample point, pulse decision only at mid-slot.
    task automatic rand_wave();
        for (int k = 0; k < NS; k++) begin
            int mode;
            int ps;
            mode = $urandom_range(0, 9);
            ps   = $urandom_range(0, M - 1);
            for (int s = 0; s < M; s++) begin
                logic [SC-1:0] w;
                logic          hit;
                w = SC'($urandom);
                if (mode < 7)      hit = (s == ps);
                else if (mode < 8) hit = 1'b0;
                else               hit = 1'($urandom);
                w[SC/2] = hit;
                wave[k][s] = w;
            end
        end
    endtask

    // Fire a frame, play `len` cycles of the waveform; fen_next says a new start pulse follows directly.
    task automatic drive_frame(input int len, input bit fen_next);
        int t;
        int lim;
        bit ferr;
        F_en   = 1'b1;
        ppm_in = 1'b0;
        t      = cyc;
        lim    = fen_next ? len + 1 : len;
        ferr   = 1'b0;
        for (int k = 0; k < NS; k++) begin
            int n;
            int first;
            n     = 0;
            first = 0;
            for (int s = 0; s < M; s++) begin
                if (wave[k][s][SC/2]) begin
                    if (n == 0) first = s;
                    n++;
                end
            end
            ferr |= (n != 1);
            if ((k + 1) * SYM_LEN <= lim) begin
                exp_t e;
                e.at   = t + 1 + (k + 1) * SYM_LEN;
                e.data = (n == 0) ? '0 : PB'(first);
                e.err  = (n != 1);
                e.done = (k == NS - 1);
                e.ferr = ferr;
                sb.push_back(e);
            end
        end
        tick();
        F_en = 1'b0;
        for (int i = 1; i <= len; i++) begin
            int p;
            p = i - 1;
            if (p < FRAME_LEN) ppm_in = wave[p / SYM_LEN][(p % SYM_LEN) / SC][p % SC];
            else               ppm_in = 1'($urandom);
            chk("busy", int'(busy), (i <= FRAME_LEN) ? 1 : 0);
            tick();
        end
        if (len == FRAME_LEN) chk("busy_at_done", int'(busy), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_out"}, int'(data_out), 0);
        chk({tag, "_data_valid"}, int'(data_valid), 0);
        chk({tag, "_sym_err"}, int'(sym_err), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int order [NS];
        order = '{0, 1, 2, 3, 3, 2, 1, 0};

        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Clean frame
        clear_wave();
        for (int k = 0; k < NS; k++) wave[k][order[k]] = '1;
        drive_frame(FRAME_LEN + 4, 1'b0);

        // Missing pulse in symbol 2, double pulse in symbol 5
        single_pulses();
        for (int s = 0; s < M; s++) begin
            wave[2][s] = '0;
            wave[5][s] = '0;
        end
        wave[5][1] = '1;
        wave[5][3] = '1;
        drive_frame(FRAME_LEN + 4, 1'b0);

        // Pulse only ahead of the sample point, then only at the sample point
        single_pulses();
        for (int s = 0; s < M; s++) wave[0][s] = '0;
        wave[0][2] = 8'h0F;
        drive_frame(FRAME_LEN + 4, 1'b0);
        single_pulses();
        for (int s = 0; s < M; s++) wave[0][s] = '0;
        wave[0][2] = 8'h10;
        drive_frame(FRAME_LEN + 4, 1'b0);

        // Restart mid-symbol, restart on a symbol boundary, restart on the final boundary
        rand_wave();
        drive_frame(49, 1'b1);
        rand_wave();
        drive_frame(63, 1'b1);
        rand_wave();
        drive_frame(FRAME_LEN - 1, 1'b1);

        // Back-to-back frames
        rand_wave();
        drive_frame(FRAME_LEN, 1'b1);
        rand_wave();
        drive_frame(FRAME_LEN + 4, 1'b0);

        // Reset mid-frame, then a quiet line with noise must produce nothing
        rand_wave();
        drive_frame(99, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("mid_reset");
        for (int i = 0; i < 300; i++) begin
            ppm_in = 1'($urandom);
            tick();
        end
        chk("idle_busy", int'(busy), 0);

        // Random frames with random restarts
        for (int f = 0; f < 5; f++) begin
            rand_wave();
            if ($urandom_range(0, 1) == 0) drive_frame(FRAME_LEN, 1'b1);
            else                           drive_frame($urandom_range(1, FRAME_LEN - 1), 1'b1);
        end
        rand_wave();
        drive_frame(FRAME_LEN + 4, 1'b0);

        repeat (10) tick();
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
